// File: rtl/z2_cycle_ctrl_pkg.sv
// Shared encodings for the Zorro II slave-cycle sequencer: bus phases and target ids.
package z2_cycle_ctrl_pkg;

  // Bus phase as seen on o_z2_state; the autoconfig block keys off these codes.
  typedef enum logic [1:0] {
    Z2_IDLE  = 2'b00,
    Z2_START = 2'b01,
    Z2_DATA  = 2'b10,
    Z2_END   = 2'b11
  } z2_state_e;

  // Which block owns the current cycle.
  typedef enum logic [1:0] {
    TGT_RAM = 2'b00,
    TGT_IDE = 2'b01,
    TGT_AC  = 2'b10
  } tgt_e;

  localparam int WCNT_W = 4;

  // Autoconfig wins over IDE, IDE wins over RAM.
  function automatic tgt_e pick_target(input logic ac, input logic ide);
    if (ac)       return TGT_AC;
    else if (ide) return TGT_IDE;
    else          return TGT_RAM;
  endfunction

endpackage

// File: rtl/z2_cycle_ctrl_sync2.sv
// Two-flop synchroniser for one asynchronous host strobe.
module z2_cycle_ctrl_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two register stages to settle metastability before the FSM sees the strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/z2_cycle_ctrl.sv
// Zorro II slave-cycle sequencer: claims host cycles for RAM/IDE/autoconfig,
// steps the shared bus phase, and produces target strobes plus a registered DTACK.
module z2_cycle_ctrl
  import z2_cycle_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned IDE_WAIT   = 3,
  parameter int unsigned AC_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_as_n,
  input  logic       i_uds_n,
  input  logic       i_lds_n,
  input  logic       i_rw,
  input  logic       i_ram_access,
  input  logic       i_ide_access,
  input  logic       i_autoconfig_cycle,
  input  logic       i_ac_dtack,
  output logic [1:0] o_z2_state,
  output logic       o_dtack,
  output logic       o_ram_oe,
  output logic [1:0] o_ram_we,
  output logic       o_ide_rd,
  output logic       o_ide_wr,
  output logic       o_data_oe,
  output logic       o_busy
);

  logic w_as_s;
  logic w_uds_s;
  logic w_lds_s;
  logic w_hit;

  z2_state_e         r_state;
  tgt_e              r_tgt;
  logic              r_rw;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_dtack;
  logic              r_ram_oe;
  logic [1:0]        r_ram_we;
  logic              r_ide_rd;
  logic              r_ide_wr;
  logic              r_data_oe;

  // Strobes are inverted ahead of the synchroniser so a reset synchroniser reads "inactive".
  z2_cycle_ctrl_sync2 u_sync_as  (.i_clk(i_clk), .i_rst(i_reset), .i_d(~i_as_n),  .o_q(w_as_s));
  z2_cycle_ctrl_sync2 u_sync_uds (.i_clk(i_clk), .i_rst(i_reset), .i_d(~i_uds_n), .o_q(w_uds_s));
  z2_cycle_ctrl_sync2 u_sync_lds (.i_clk(i_clk), .i_rst(i_reset), .i_d(~i_lds_n), .o_q(w_lds_s));

  assign w_hit = i_ram_access | i_ide_access | i_autoconfig_cycle;

  // Cycle sequencer with all host/target strobes registered alongside the phase.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= Z2_IDLE;
      r_tgt     <= TGT_RAM;
      r_rw      <= 1'b0;
      r_wcnt    <= '0;
      r_dtack   <= 1'b0;
      r_ram_oe  <= 1'b0;
      r_ram_we  <= 2'b00;
      r_ide_rd  <= 1'b0;
      r_ide_wr  <= 1'b0;
      r_data_oe <= 1'b0;
    end else if (!w_as_s && r_state != Z2_IDLE) begin
      // Host released AS: normal end of cycle from END, abort from START/DATA.
      r_state   <= Z2_IDLE;
      r_dtack   <= 1'b0;
      r_ram_oe  <= 1'b0;
      r_ram_we  <= 2'b00;
      r_ide_rd  <= 1'b0;
      r_ide_wr  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      case (r_state)
        Z2_IDLE: begin
          if (w_as_s && w_hit) begin
            r_state <= Z2_START;
            r_tgt   <= pick_target(i_autoconfig_cycle, i_ide_access);
            r_rw    <= i_rw;
          end
        end
        Z2_START: begin
          if (r_rw || w_uds_s || w_lds_s) begin
            r_state   <= Z2_DATA;
            r_ram_oe  <= r_rw && (r_tgt == TGT_RAM);
            r_ram_we  <= (!r_rw && r_tgt == TGT_RAM) ? {w_uds_s, w_lds_s} : 2'b00;
            r_ide_rd  <= r_rw && (r_tgt == TGT_IDE);
            r_ide_wr  <= !r_rw && (r_tgt == TGT_IDE);
            r_data_oe <= r_rw;
            case (r_tgt)
              TGT_IDE: r_wcnt <= WCNT_W'(IDE_WAIT);
              TGT_AC:  r_wcnt <= WCNT_W'(AC_TIMEOUT - 1);
              default: r_wcnt <= WCNT_W'(RAM_WAIT);
            endcase
          end
        end
        Z2_DATA: begin
          if (r_tgt == TGT_AC && i_ac_dtack) begin
            r_state  <= Z2_END;
            r_dtack  <= 1'b1;
            r_ram_we <= 2'b00;
            r_ide_wr <= 1'b0;
          end else if (r_wcnt == '0) begin
            // An autoconfig timeout ends without DTACK so the host bus-errors.
            r_state  <= Z2_END;
            r_dtack  <= (r_tgt != TGT_AC);
            r_ram_we <= 2'b00;
            r_ide_wr <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_z2_state = r_state;
  assign o_dtack    = r_dtack;
  assign o_ram_oe   = r_ram_oe;
  assign o_ram_we   = r_ram_we;
  assign o_ide_rd   = r_ide_rd;
  assign o_ide_wr   = r_ide_wr;
  assign o_data_oe  = r_data_oe;
  assign o_busy     = (r_state != Z2_IDLE);

endmodule
